// File: rtl/mux_9_5_scanner_if.sv
// Bundle between the channel-mux scanner and its controller/mux environment.
// master = scanner side (drives Sel and the sample outputs), slave = environment.
interface mux_9_5_scanner_if #(
  parameter int N_CH    = 9,
  parameter int SEL_W   = 4,
  parameter int DATA_W  = 5,
  parameter int DWELL_W = 4
);
  logic                start;
  logic                stop;
  logic                cont;
  logic [N_CH-1:0]     en_mask;
  logic [DWELL_W-1:0]  dwell;
  logic [DATA_W-1:0]   y_in;
  logic [SEL_W-1:0]    Sel;
  logic [DATA_W-1:0]   sample;
  logic [SEL_W-1:0]    sample_ch;
  logic                sample_valid;
  logic                frame_done;
  logic                busy;

  modport master (
    input  start, stop, cont, en_mask, dwell, y_in,
    output Sel, sample, sample_ch, sample_valid, frame_done, busy
  );

  modport slave (
    output start, stop, cont, en_mask, dwell, y_in,
    input  Sel, sample, sample_ch, sample_valid, frame_done, busy
  );
endinterface

// File: rtl/mux_9_5_scanner.sv
// Sequencer for the 9:1 x 5-bit channel mux: walks Sel over enabled channels,
// waits a settle time on each, then registers Y with its channel index.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no frame active; waits for start with a non-zero mask
//  SETTLE  | Sel driven, counting down the per-channel settle time
//  CAPTURE | one cycle; Y captured at the closing edge, next channel chosen
module mux_9_5_scanner #(
  parameter int N_CH    = 9,
  parameter int SEL_W   = 4,
  parameter int DATA_W  = 5,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  mux_9_5_scanner_if.master     bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DWELL_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]     mask_q, mask_d;
  logic                cont_q, cont_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [SEL_W-1:0]    sample_ch_q, sample_ch_d;
  logic                sample_valid_q, sample_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;

  logic [SEL_W-1:0]    first_in;
  logic [SEL_W-1:0]    first_lat;
  logic [SEL_W-1:0]    next_lat;
  logic                next_ok;

  // Priority searches: scanning downward leaves the lowest matching index.
  always_comb begin
    first_in  = '0;
    first_lat = '0;
    next_lat  = '0;
    next_ok   = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.en_mask[i]) begin
        first_in = SEL_W'(i);
      end
      if (mask_q[i]) begin
        first_lat = SEL_W'(i);
      end
      if (mask_q[i] && (SEL_W'(i) > sel_q)) begin
        next_lat = SEL_W'(i);
        next_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    cont_d         = cont_q;
    dwell_d        = dwell_q;
    sample_d       = sample_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.en_mask != '0)) begin
          mask_d  = bus.en_mask;
          cont_d  = bus.cont;
          dwell_d = bus.dwell;
          cnt_d   = bus.dwell;
          sel_d   = first_in;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // stop wins over the capture: nothing is reported on an aborted edge
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          sample_d       = bus.y_in;
          sample_ch_d    = sel_q;
          sample_valid_d = 1'b1;
          if (next_ok) begin
            sel_d   = next_lat;
            cnt_d   = dwell_q;
            state_d = SETTLE;
          end else begin
            frame_done_d = 1'b1;
            if (cont_q) begin
              sel_d   = first_lat;
              cnt_d   = dwell_q;
              state_d = SETTLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      cnt_q          <= '0;
      mask_q         <= '0;
      cont_q         <= 1'b0;
      dwell_q        <= '0;
      sample_q       <= '0;
      sample_ch_q    <= '0;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      cont_q         <= cont_d;
      dwell_q        <= dwell_d;
      sample_q       <= sample_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.Sel          = sel_q;
  assign bus.sample       = sample_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mux_9_5_scanner.sv
// Bench for mux_9_5_scanner: random mux data and frame settings checked against
// an arithmetic model of the scan timeline (period = dwell+2 edges per channel).
module tb_mux_9_5_scanner;
  localparam int N_CH    = 9;
  localparam int SEL_W   = 4;
  localparam int DATA_W  = 5;
  localparam int DWELL_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_9_5_scanner_if #(.N_CH(N_CH), .SEL_W(SEL_W), .DATA_W(DATA_W), .DWELL_W(DWELL_W)) bus ();

  logic [DATA_W-1:0] d_tab [N_CH];
  assign bus.y_in = (bus.Sel < SEL_W'(N_CH)) ? d_tab[bus.Sel] : '0;

  mux_9_5_scanner #(.N_CH(N_CH), .SEL_W(SEL_W), .DATA_W(DATA_W), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int chans[$];
  logic [SEL_W-1:0]  exp_ch;
  logic [DATA_W-1:0] exp_smp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected Sel after edge u of a frame that was never stopped.
  function automatic int sel_at(int u, int p, bit ct);
    int n;
    n = chans.size();
    if (!ct && u >= n * p) return chans[n-1];
    return chans[(u / p) % n];
  endfunction

  // Runs one frame starting now; edge t=0 is the start-accepting edge.
  task automatic run_frame(input logic [N_CH-1:0] mask, input logic [DWELL_W-1:0] dw,
                           input logic ct, input int stop_t, input bit mutate,
                           input int n_edges, output int n_valid);
    int n, p, j, esel;
    bit stopped, ev, efd, ebusy;
    chans.delete();
    for (int i = 0; i < N_CH; i++) if (mask[i]) chans.push_back(i);
    for (int i = 0; i < N_CH; i++) d_tab[i] = DATA_W'($urandom);
    n = chans.size();
    p = int'(dw) + 2;
    n_valid = 0;
    bus.en_mask = mask;
    bus.dwell   = dw;
    bus.cont    = ct;
    bus.start   = 1'b1;
    for (int t = 0; t <= n_edges; t++) begin
      if (t == stop_t) bus.stop = 1'b1;
      step();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (mutate && t == 2) begin
        bus.start   = 1'b1;
        bus.en_mask = ~mask;
        bus.dwell   = dw + 4'd3;
        bus.cont    = ~ct;
      end
      stopped = (stop_t >= 1) && (t >= stop_t);
      j = t / p - 1;
      if (stopped) begin
        ev = 0; efd = 0; ebusy = 0;
        esel = sel_at(stop_t - 1, p, ct);
      end else begin
        ev    = (t > 0) && (t % p == 0) && (ct || (t / p) <= n);
        efd   = ev && (j % n == n - 1);
        ebusy = ct || (t < n * p);
        esel  = sel_at(t, p, ct);
      end
      if (ev) begin
        exp_ch  = SEL_W'(chans[j % n]);
        exp_smp = d_tab[exp_ch];
      end
      tests += 6;
      if (bus.sample_valid !== ev) begin
        fails++; $display("FAIL frame_valid t=%0d got %0b exp %0b", t, bus.sample_valid, ev);
      end
      if (bus.frame_done !== efd) begin
        fails++; $display("FAIL frame_done t=%0d got %0b exp %0b", t, bus.frame_done, efd);
      end
      if (bus.busy !== ebusy) begin
        fails++; $display("FAIL frame_busy t=%0d got %0b exp %0b", t, bus.busy, ebusy);
      end
      if (bus.Sel !== SEL_W'(esel)) begin
        fails++; $display("FAIL frame_sel t=%0d got %0d exp %0d", t, bus.Sel, esel);
      end
      if (bus.sample_ch !== exp_ch) begin
        fails++; $display("FAIL frame_sample_ch t=%0d got %0d exp %0d", t, bus.sample_ch, exp_ch);
      end
      if (bus.sample !== exp_smp) begin
        fails++; $display("FAIL frame_sample t=%0d got %0h exp %0h", t, bus.sample, exp_smp);
      end
      if (bus.sample_valid === 1'b1) n_valid++;
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b1; bus.en_mask = 9'h1FF; bus.dwell = 4'd2; bus.cont = 1'b1; bus.stop = 1'b0;
    step(); step();
    bus.start = 1'b0;
    tests += 6;
    if (bus.Sel !== 4'd0)          begin fails++; $display("FAIL reset_sel got %0d exp 0", bus.Sel); end
    if (bus.sample !== 5'd0)       begin fails++; $display("FAIL reset_sample got %0h exp 0", bus.sample); end
    if (bus.sample_ch !== 4'd0)    begin fails++; $display("FAIL reset_sample_ch got %0d exp 0", bus.sample_ch); end
    if (bus.sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b exp 0", bus.sample_valid); end
    if (bus.frame_done !== 1'b0)   begin fails++; $display("FAIL reset_frame_done got %0b exp 0", bus.frame_done); end
    if (bus.busy !== 1'b0)         begin fails++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    reset = 1'b0;
    exp_ch = '0; exp_smp = '0;
    step();
  endtask

  task automatic test_full_scan();
    int nv;
    run_frame(9'h1FF, 4'd0, 1'b0, -1, 1'b0, 22, nv);
    tests++;
    if (nv != 9) begin fails++; $display("FAIL full_scan_count got %0d exp 9", nv); end
  endtask

  task automatic test_sparse();
    int nv;
    run_frame(9'b100010001, 4'd3, 1'b0, -1, 1'b0, 18, nv);
    tests++;
    if (nv != 3) begin fails++; $display("FAIL sparse_count got %0d exp 3", nv); end
  endtask

  task automatic test_cont_stop();
    int nv;
    run_frame(9'b000000110, 4'd1, 1'b1, 13, 1'b0, 18, nv);
    tests++;
    if (nv != 4) begin fails++; $display("FAIL cont_stop_count got %0d exp 4", nv); end
  endtask

  task automatic test_stop_capture();
    int nv;
    run_frame(9'h1FF, 4'd2, 1'b0, 12, 1'b0, 15, nv);
    tests += 2;
    if (nv != 2) begin fails++; $display("FAIL stop_capture_count got %0d exp 2", nv); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL stop_capture_busy got %0b exp 0", bus.busy); end
  endtask

  task automatic test_ignored_inputs();
    int nv;
    run_frame(9'b011010101, 4'd2, 1'b0, -1, 1'b1, 23, nv);
    tests++;
    if (nv != 5) begin fails++; $display("FAIL ignored_inputs_count got %0d exp 5", nv); end
  endtask

  task automatic test_reset_mid_frame();
    bus.en_mask = 9'h1FF; bus.dwell = 4'd1; bus.cont = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    reset = 1'b1;
    step();
    tests += 6;
    if (bus.Sel !== 4'd0)          begin fails++; $display("FAIL midreset_sel got %0d exp 0", bus.Sel); end
    if (bus.sample !== 5'd0)       begin fails++; $display("FAIL midreset_sample got %0h exp 0", bus.sample); end
    if (bus.sample_ch !== 4'd0)    begin fails++; $display("FAIL midreset_sample_ch got %0d exp 0", bus.sample_ch); end
    if (bus.sample_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid got %0b exp 0", bus.sample_valid); end
    if (bus.frame_done !== 1'b0)   begin fails++; $display("FAIL midreset_frame_done got %0b exp 0", bus.frame_done); end
    if (bus.busy !== 1'b0)         begin fails++; $display("FAIL midreset_busy got %0b exp 0", bus.busy); end
    reset = 1'b0;
    exp_ch = '0; exp_smp = '0;
    step();
  endtask

  task automatic test_zero_mask();
    bus.en_mask = '0; bus.dwell = 4'd0; bus.cont = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests += 2;
      if (bus.busy !== 1'b0)         begin fails++; $display("FAIL zero_mask_busy cyc=%0d got %0b exp 0", i, bus.busy); end
      if (bus.sample_valid !== 1'b0) begin fails++; $display("FAIL zero_mask_valid cyc=%0d got %0b exp 0", i, bus.sample_valid); end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_random();
    logic [N_CH-1:0] mask;
    logic [DWELL_W-1:0] dw;
    logic ct;
    int n, p, st, nv, env;
    for (int k = 0; k < 10; k++) begin
      mask = N_CH'($urandom_range(1, 511));
      dw   = DWELL_W'($urandom_range(0, 4));
      ct   = 1'($urandom_range(0, 1));
      n = 0;
      for (int i = 0; i < N_CH; i++) if (mask[i]) n++;
      p = int'(dw) + 2;
      st = (ct || $urandom_range(0, 1) == 1) ? int'($urandom_range(1, n * p)) : -1;
      run_frame(mask, dw, ct, st, 1'b0, n * p + 4, nv);
      if (st < 0) env = n;
      else begin
        env = (st - 1) / p;
        if (!ct && env > n) env = n;
      end
      tests++;
      if (nv != env) begin fails++; $display("FAIL random_count iter=%0d got %0d exp %0d", k, nv, env); end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0; bus.en_mask = '0; bus.dwell = '0;
    for (int i = 0; i < N_CH; i++) d_tab[i] = '0;
    exp_ch = '0; exp_smp = '0;
    test_reset();
    test_full_scan();
    test_sparse();
    test_cont_stop();
    test_stop_capture();
    test_reset_mid_frame();
    test_zero_mask();
    test_ignored_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
